// File: rtl/tdm_demux.sv
// tdm_demux: receive-side time-division demultiplexer.
// Recovers CHANNELS parallel slot values from one time-multiplexed line.
// The line carries one slot per enabled clock. Slot 0 of each frame is marked by F.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   E     slot enable; a slot is consumed only when E=1
//   D     slot data (WIDTH bits)
//   F     frame sync, marks slot 0 (meaningful only when E=1)
//   Y     last complete frame, slot i at Y[i*WIDTH +: WIDTH]
//   S     index of the slot consumed on the next enabled edge
//   V     one-cycle strobe when Y is updated with a new frame
//   LOCK  high while frame-aligned
//   ERR   sticky sync-error flag, cleared only by rst
module tdm_demux #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned WIDTH    = 1,
   parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      E,
   input  logic [WIDTH-1:0]          D,
   input  logic                      F,
   output logic [CHANNELS*WIDTH-1:0] Y,
   output logic [SEL_W-1:0]          S,
   output logic                      V,
   output logic                      LOCK,
   output logic                      ERR
);

   typedef enum logic [0:0] {StHunt, StLocked} state_e;

   localparam logic [SEL_W-1:0] LastSlot = SEL_W'(CHANNELS - 1);

   state_e                      state_q;
   logic [SEL_W-1:0]            cnt_q;
   logic [CHANNELS*WIDTH-1:0]   shadow_q;
   logic [CHANNELS*WIDTH-1:0]   y_q;
   logic                        v_q;
   logic                        lock_q;
   logic                        err_q;

   // Shadow with the current slot replaced by D; used both to update the
   // shadow and to publish a completed frame in the same edge.
   logic [CHANNELS*WIDTH-1:0]   shadow_wr;
   int unsigned                 base;
   logic                        sync_ok;

   always_comb begin
      base      = 32'(cnt_q) * WIDTH;
      shadow_wr = shadow_q;
      shadow_wr[base +: WIDTH] = D;
      // F must be present exactly on slot 0 while locked.
      sync_ok   = ((cnt_q == '0) == F);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StHunt;
         cnt_q    <= '0;
         shadow_q <= '0;
         y_q      <= '0;
         v_q      <= 1'b0;
         lock_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         v_q <= 1'b0;
         if (E) begin
            unique case (state_q)
               StHunt: begin
                  if (F) begin
                     shadow_q <= shadow_wr;
                     cnt_q    <= SEL_W'(1);
                     state_q  <= StLocked;
                     lock_q   <= 1'b1;
                  end
               end
               StLocked: begin
                  if (sync_ok) begin
                     shadow_q <= shadow_wr;
                     if (cnt_q == LastSlot) begin
                        y_q   <= shadow_wr;
                        v_q   <= 1'b1;
                        cnt_q <= '0;
                     end else begin
                        cnt_q <= cnt_q + SEL_W'(1);
                     end
                  end else begin
                     // Early or missing sync: drop the partial frame and re-hunt.
                     err_q   <= 1'b1;
                     lock_q  <= 1'b0;
                     state_q <= StHunt;
                     cnt_q   <= '0;
                  end
               end
               default: begin
                  state_q <= StHunt;
                  cnt_q   <= '0;
                  lock_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign Y    = y_q;
   assign S    = cnt_q;
   assign V    = v_q;
   assign LOCK = lock_q;
   assign ERR  = err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: scoreboard bench for tdm_demux with directed and random slots.
module tb_tdm_demux;

   localparam int unsigned CHANNELS = 4;
   localparam int unsigned WIDTH    = 1;
   localparam int unsigned SEL_W    = $clog2(CHANNELS);
   localparam int unsigned YW       = CHANNELS * WIDTH;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             E   = 1'b0;
   logic [WIDTH-1:0] D   = '0;
   logic             F   = 1'b0;
   logic [YW-1:0]    Y;
   logic [SEL_W-1:0] S;
   logic             V;
   logic             LOCK;
   logic             ERR;

   tdm_demux #(
      .CHANNELS(CHANNELS),
      .WIDTH   (WIDTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .E   (E),
      .D   (D),
      .F   (F),
      .Y   (Y),
      .S   (S),
      .V   (V),
      .LOCK(LOCK),
      .ERR (ERR)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [SEL_W-1:0] s;
      logic             lock;
      logic             err;
      logic             v;
      logic [YW-1:0]    y;
   } status_t;

   status_t          exp_q[$];
   logic [YW-1:0]    frm_q[$];

   int checks = 0;
   int errors = 0;

   // Reference model: a list of slots collected so far in the current frame.
   bit               m_locked = 1'b0;
   logic [WIDTH-1:0] m_part[$];
   logic [YW-1:0]    m_y = '0;
   logic             m_err = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic model(input logic r, input logic e, input logic f, input logic [WIDTH-1:0] d);
      status_t st;
      logic    v;
      v = 1'b0;
      if (r) begin
         m_locked = 1'b0;
         m_part.delete();
         m_y   = '0;
         m_err = 1'b0;
      end else if (e) begin
         if (!m_locked) begin
            if (f) begin
               m_locked = 1'b1;
               m_part.push_back(d);
            end
         end else if (f != (m_part.size() == 0)) begin
            m_err    = 1'b1;
            m_locked = 1'b0;
            m_part.delete();
         end else begin
            m_part.push_back(d);
            if (m_part.size() == CHANNELS) begin
               for (int i = 0; i < CHANNELS; i++) m_y[i*WIDTH +: WIDTH] = m_part[i];
               v = 1'b1;
               frm_q.push_back(m_y);
               m_part.delete();
            end
         end
      end
      st.s    = SEL_W'(m_part.size());
      st.lock = m_locked;
      st.err  = m_err;
      st.v    = v;
      st.y    = m_y;
      exp_q.push_back(st);
   endtask

   task automatic cyc(input logic r, input logic e, input logic f, input logic [WIDTH-1:0] d);
      rst = r;
      E   = e;
      F   = f;
      D   = d;
      @(posedge clk);
      model(r, e, f, d);
      #1;
   endtask

   task automatic slot(input logic f, input logic [WIDTH-1:0] d);
      cyc(1'b0, 1'b1, f, d);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'($urandom), WIDTH'($urandom));
   endtask

   // Monitor: per-cycle status against the model, frames popped on V.
   always @(negedge clk) begin
      status_t st;
      if (exp_q.size() > 0) begin
         st = exp_q.pop_front();
         chk("S", 32'(S), 32'(st.s));
         chk("LOCK", 32'(LOCK), 32'(st.lock));
         chk("ERR", 32'(ERR), 32'(st.err));
         chk("V", 32'(V), 32'(st.v));
         chk("Y_hold", 32'(Y), 32'(st.y));
         if (V === 1'b1) begin
            if (frm_q.size() == 0) chk("V_unexpected", 32'(V), 32'd0);
            else chk("frame_Y", 32'(Y), 32'(frm_q.pop_front()));
         end
      end
   end

   initial begin
      int pos;
      logic f;
      // Reset with random inputs.
      for (int i = 0; i < 2; i++) cyc(1'b1, 1'($urandom), 1'($urandom), WIDTH'($urandom));
      chk("rst_Y", 32'(Y), 32'd0);
      chk("rst_S", 32'(S), 32'd0);
      chk("rst_V", 32'(V), 32'd0);
      chk("rst_LOCK", 32'(LOCK), 32'd0);
      chk("rst_ERR", 32'(ERR), 32'd0);

      // Basic frame.
      slot(1'b1, 1'b1);
      chk("basic_S1", 32'(S), 32'd1);
      chk("basic_LOCK", 32'(LOCK), 32'd1);
      slot(1'b0, 1'b0);
      chk("basic_S2", 32'(S), 32'd2);
      slot(1'b0, 1'b1);
      chk("basic_S3", 32'(S), 32'd3);
      chk("basic_noV", 32'(V), 32'd0);
      slot(1'b0, 1'b0);
      chk("basic_S0", 32'(S), 32'd0);
      chk("basic_Y", 32'(Y), 32'b0101);
      chk("basic_V", 32'(V), 32'd1);
      idle();
      chk("basic_Vone", 32'(V), 32'd0);

      // Enable gaps between slots 1 and 2.
      slot(1'b1, 1'b1);
      slot(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle();
         chk("gap_S", 32'(S), 32'd2);
         chk("gap_V", 32'(V), 32'd0);
      end
      slot(1'b0, 1'b1);
      slot(1'b0, 1'b0);
      chk("gap_Y", 32'(Y), 32'b0101);
      chk("gap_V1", 32'(V), 32'd1);

      // Reset mid-frame.
      slot(1'b1, 1'b0);
      slot(1'b0, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      chk("midrst_Y", 32'(Y), 32'd0);
      chk("midrst_S", 32'(S), 32'd0);
      chk("midrst_LOCK", 32'(LOCK), 32'd0);

      // Hunt: no capture before sync.
      for (int i = 0; i < 5; i++) begin
         slot(1'b0, WIDTH'($urandom));
         chk("hunt_S", 32'(S), 32'd0);
         chk("hunt_LOCK", 32'(LOCK), 32'd0);
      end
      slot(1'b1, 1'b1);
      slot(1'b0, 1'b1);
      slot(1'b0, 1'b0);
      slot(1'b0, 1'b1);
      chk("hunt_Y", 32'(Y), 32'b1011);

      // Early sync after a good frame.
      slot(1'b1, 1'b1);
      slot(1'b0, 1'b0);
      slot(1'b0, 1'b1);
      slot(1'b0, 1'b0);
      slot(1'b1, 1'b1);
      slot(1'b0, 1'b1);
      slot(1'b1, 1'b1);
      chk("early_ERR", 32'(ERR), 32'd1);
      chk("early_LOCK", 32'(LOCK), 32'd0);
      chk("early_S", 32'(S), 32'd0);
      chk("early_Y", 32'(Y), 32'b0101);
      chk("early_V", 32'(V), 32'd0);
      slot(1'b1, 1'b0);
      slot(1'b0, 1'b0);
      slot(1'b0, 1'b0);
      slot(1'b0, 1'b1);
      chk("early_next_Y", 32'(Y), 32'b1000);
      chk("early_next_V", 32'(V), 32'd1);
      chk("early_ERR_sticky", 32'(ERR), 32'd1);

      // Missing sync on second frame.
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < CHANNELS; i++) slot(i == 0, WIDTH'($urandom));
      chk("miss_V1", 32'(V), 32'd1);
      slot(1'b0, 1'b1);
      chk("miss_ERR", 32'(ERR), 32'd1);
      chk("miss_LOCK", 32'(LOCK), 32'd0);
      for (int i = 1; i < CHANNELS; i++) begin
         slot(1'b0, WIDTH'($urandom));
         chk("miss_noV", 32'(V), 32'd0);
      end

      // Random traffic, sync mostly well-placed, occasional reset.
      for (int i = 0; i < 3000; i++) begin
         pos = m_part.size();
         f = (pos == 0);
         if ($urandom_range(0, 9) == 0) f = ~f;
         cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), f, WIDTH'($urandom));
      end

      idle();
      idle();
      @(negedge clk);
      #1;
      chk("frames_drained", 32'(frm_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
